// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: RAW forwarding, load-use stalls, branch flushes and MUL/DIV wait.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned NSTG       = 3,
  parameter int unsigned LOAD_RDY   = 2,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rs1_used_id,
  input  logic                    rs2_used_id,
  input  logic [RADDR_W-1:0]      rs1_addr_id,
  input  logic [RADDR_W-1:0]      rs2_addr_id,
  input  logic [NSTG-1:0]         stg_we,
  input  logic [NSTG*RADDR_W-1:0] stg_wr,
  input  logic [NSTG*XLEN-1:0]    stg_wd,
  input  logic [NSTG-1:0]         stg_is_load,
  input  logic                    md_start_ex,
  input  logic                    md_done,
  input  logic                    branch_taken_ex,
  output logic                    keep_pc,
  output logic                    stall_if_id,
  output logic                    stall_id_ex,
  output logic                    stall_ex,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    fwd1_en,
  output logic                    fwd2_en,
  output logic [XLEN-1:0]         fwd1_data,
  output logic [XLEN-1:0]         fwd2_data,
  output logic                    md_timeout
`ifdef HAZARD_PERF_EN
  ,
  input  logic                    perf_clr,
  output logic [31:0]             perf_lu_cnt,
  output logic [31:0]             perf_md_cnt,
  output logic [31:0]             perf_fl_cnt
`endif
);

  localparam int unsigned CW = $clog2(MD_TIMEOUT) + 1;

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           lu1, lu2, load_use;
  logic           lu_stall, md_wait_cyc, br_flush;

  // Youngest hit wins; a not-yet-ready load blocks forwarding from any older stage.
  always_comb begin
    logic hit1, hit2;
    hit1      = 1'b0;
    hit2      = 1'b0;
    lu1       = 1'b0;
    lu2       = 1'b0;
    fwd1_en   = 1'b0;
    fwd2_en   = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (!hit1 && rs1_used_id && stg_we[i] && (stg_wr[i*RADDR_W +: RADDR_W] == rs1_addr_id)
          && (stg_wr[i*RADDR_W +: RADDR_W] != '0)) begin
        hit1 = 1'b1;
        if (stg_is_load[i] && (i < LOAD_RDY)) begin
          lu1 = 1'b1;
        end else begin
          fwd1_en   = 1'b1;
          fwd1_data = stg_wd[i*XLEN +: XLEN];
        end
      end
      if (!hit2 && rs2_used_id && stg_we[i] && (stg_wr[i*RADDR_W +: RADDR_W] == rs2_addr_id)
          && (stg_wr[i*RADDR_W +: RADDR_W] != '0)) begin
        hit2 = 1'b1;
        if (stg_is_load[i] && (i < LOAD_RDY)) begin
          lu2 = 1'b1;
        end else begin
          fwd2_en   = 1'b1;
          fwd2_data = stg_wd[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign load_use = lu1 | lu2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    keep_pc     = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    stall_ex    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    md_timeout  = 1'b0;
    lu_stall    = 1'b0;
    md_wait_cyc = 1'b0;
    br_flush    = 1'b0;
    if ((state_q == StMdWait) && !md_done) begin
      // EX is frozen, so branch and load-use inputs are meaningless here.
      keep_pc     = 1'b1;
      stall_if_id = 1'b1;
      stall_id_ex = 1'b1;
      stall_ex    = 1'b1;
      md_wait_cyc = 1'b1;
      cnt_d       = cnt_q + CW'(1);
      if (cnt_q == CW'(MD_TIMEOUT - 1)) begin
        md_timeout = 1'b1;
        state_d    = StRun;
        cnt_d      = '0;
      end
    end else begin
      state_d = StRun;
      cnt_d   = '0;
      if (md_start_ex && !md_done) begin
        state_d     = StMdWait;
        keep_pc     = 1'b1;
        stall_if_id = 1'b1;
        stall_id_ex = 1'b1;
        stall_ex    = 1'b1;
      end else if (branch_taken_ex) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        br_flush    = 1'b1;
      end else if (load_use) begin
        keep_pc     = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
        lu_stall    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_cnt <= '0;
      perf_md_cnt <= '0;
      perf_fl_cnt <= '0;
    end else if (perf_clr) begin
      perf_lu_cnt <= '0;
      perf_md_cnt <= '0;
      perf_fl_cnt <= '0;
    end else begin
      if (lu_stall && (perf_lu_cnt != 32'hFFFF_FFFF)) perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (md_wait_cyc && (perf_md_cnt != 32'hFFFF_FFFF)) perf_md_cnt <= perf_md_cnt + 32'd1;
      if (br_flush && (perf_fl_cnt != 32'hFFFF_FFFF)) perf_fl_cnt <= perf_fl_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lu_stall ^ md_wait_cyc ^ br_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit with hand-computed expectations.
module tb_hazard_ctrl_unit;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NS   = 3;

  logic             clk, rst_n;
  logic             rs1_used_id, rs2_used_id;
  logic [RW-1:0]    rs1_addr_id, rs2_addr_id;
  logic [NS-1:0]    stg_we, stg_is_load;
  logic [NS*RW-1:0] stg_wr;
  logic [NS*XLEN-1:0] stg_wd;
  logic             md_start_ex, md_done, branch_taken_ex;
  logic             keep_pc, stall_if_id, stall_id_ex, stall_ex;
  logic             flush_if_id, flush_id_ex, fwd1_en, fwd2_en, md_timeout;
  logic [XLEN-1:0]  fwd1_data, fwd2_data;
`ifdef HAZARD_PERF_EN
  logic             perf_clr;
  logic [31:0]      perf_lu_cnt, perf_md_cnt, perf_fl_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .stg_we(stg_we), .stg_wr(stg_wr), .stg_wd(stg_wd), .stg_is_load(stg_is_load),
    .md_start_ex(md_start_ex), .md_done(md_done), .branch_taken_ex(branch_taken_ex),
    .keep_pc(keep_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex(stall_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .md_timeout(md_timeout)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .perf_lu_cnt(perf_lu_cnt), .perf_md_cnt(perf_md_cnt),
    .perf_fl_cnt(perf_fl_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {keep_pc,stall_if_id,stall_id_ex,stall_ex,flush_if_id,flush_id_ex}
  function automatic logic [31:0] ctl();
    return {26'd0, keep_pc, stall_if_id, stall_id_ex, stall_ex, flush_if_id, flush_id_ex};
  endfunction

  task automatic clear_in();
    rs1_used_id = 0; rs2_used_id = 0; rs1_addr_id = 0; rs2_addr_id = 0;
    stg_we = 0; stg_wr = 0; stg_wd = 0; stg_is_load = 0;
    md_start_ex = 0; md_done = 0; branch_taken_ex = 0;
  endtask

  task automatic set_stg(input int i, input logic we, input logic [RW-1:0] wr,
                         input logic [XLEN-1:0] wd, input logic ld);
    stg_we[i] = we;
    stg_wr[i*RW +: RW] = wr;
    stg_wd[i*XLEN +: XLEN] = wd;
    stg_is_load[i] = ld;
  endtask

  // Advance to just after the next rising edge, leaving room to drive then sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int early;
    clear_in();
`ifdef HAZARD_PERF_EN
    perf_clr = 0;
`endif
    rst_n = 0;
    #12;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_fwd", {30'd0, fwd1_en, fwd2_en}, 32'h0);
    chk("reset_tmo", {31'd0, md_timeout}, 32'h0);
    rst_n = 1;
    tick();

    // 1: simple EX forward
    set_stg(0, 1, 5, 32'hA5, 0);
    rs1_used_id = 1; rs1_addr_id = 5;
    #1;
    chk("t1_fwd1_en", {31'd0, fwd1_en}, 32'd1);
    chk("t1_fwd1_data", fwd1_data, 32'hA5);
    chk("t1_ctl", ctl(), 32'h0);
    chk("t1_fwd2_en", {31'd0, fwd2_en}, 32'd0);

    // 2: youngest wins; x0 destination never forwards
    tick(); clear_in();
    set_stg(0, 1, 7, 32'd1, 0);
    set_stg(2, 1, 7, 32'd2, 0);
    rs2_used_id = 1; rs2_addr_id = 7; rs1_addr_id = 7;
    #1;
    chk("t2_fwd2_data_ex", fwd2_data, 32'd1);
    chk("t2_fwd1_unused", {31'd0, fwd1_en}, 32'd0);
    set_stg(0, 1, 0, 32'd1, 0);
    #1;
    chk("t2_fwd2_data_wb", fwd2_data, 32'd2);
    chk("t2_fwd2_en_wb", {31'd0, fwd2_en}, 32'd1);
    rs2_addr_id = 0;
    #1;
    chk("t2_x0_no_fwd", {31'd0, fwd2_en}, 32'd0);

    // 3: load-use through EX and MEM, WB holds stale x3 that must not be used
    tick(); clear_in();
    rs1_used_id = 1; rs1_addr_id = 3;
    set_stg(0, 1, 3, 32'd33, 1);
    set_stg(2, 1, 3, 32'd9, 0);
    #1;
    chk("t3_lu_ex_ctl", ctl(), 32'b110001);
    chk("t3_lu_ex_nofwd", {31'd0, fwd1_en}, 32'd0);
    tick();
    set_stg(0, 0, 0, 0, 0);
    set_stg(1, 1, 3, 32'd33, 1);
    #1;
    chk("t3_lu_mem_ctl", ctl(), 32'b110001);
    tick();
    set_stg(1, 0, 0, 0, 0);
    set_stg(2, 1, 3, 32'd33, 1);
    #1;
    chk("t3_wb_ctl", ctl(), 32'h0);
    chk("t3_wb_fwd", fwd1_data, 32'd33);
`ifdef HAZARD_PERF_EN
    tick(); clear_in(); #1;
    chk("perf_lu", perf_lu_cnt, 32'd2);
`endif

    // 4: MD op with done 5 cycles later; hazards ignored while waiting
    tick(); clear_in();
    md_start_ex = 1;
    #1;
    chk("t4_start_ctl", ctl(), 32'b111100);
    for (int k = 1; k <= 4; k++) begin
      tick(); clear_in();
      if (k == 2) begin
        branch_taken_ex = 1;
        rs1_used_id = 1; rs1_addr_id = 3;
        set_stg(0, 1, 3, 32'd1, 1);
      end
      #1;
      chk($sformatf("t4_wait_ctl_%0d", k), ctl(), 32'b111100);
    end
    tick(); clear_in();
    md_done = 1;
    #1;
    chk("t4_done_ctl", ctl(), 32'h0);
    tick(); clear_in(); #1;
    chk("t4_after_ctl", ctl(), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("perf_md", perf_md_cnt, 32'd4);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    #1;
    chk("perf_clr_lu", perf_lu_cnt, 32'd0);
    chk("perf_clr_md", perf_md_cnt, 32'd0);
`endif
    md_start_ex = 1; md_done = 1;
    #1;
    chk("t4_single_ctl", ctl(), 32'h0);
    tick(); clear_in(); #1;
    chk("t4_single_next", ctl(), 32'h0);

    // 5: branch beats load-use, then watchdog
    rs1_used_id = 1; rs1_addr_id = 3;
    set_stg(0, 1, 3, 32'd1, 1);
    branch_taken_ex = 1;
    #1;
    chk("t5_branch_ctl", ctl(), 32'b000011);
    tick(); clear_in();
    md_start_ex = 1;
    early = 0;
    for (int k = 1; k <= 63; k++) begin
      tick(); clear_in(); #1;
      if (md_timeout !== 1'b0 || stall_ex !== 1'b1) early++;
    end
    chk("t5_no_early_tmo", early, 32'd0);
    tick(); #1;
    chk("t5_tmo_pulse", {31'd0, md_timeout}, 32'd1);
    tick(); #1;
    chk("t5_tmo_clear", {31'd0, md_timeout}, 32'd0);
    chk("t5_back_run", ctl(), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("perf_fl", perf_fl_cnt, 32'd1);
`endif

    // 6: async reset mid-wait
    md_start_ex = 1;
    tick(); clear_in();
    tick(); #1;
    chk("t6_waiting", ctl(), 32'b111100);
    rst_n = 0;
    #1;
    chk("t6_rst_ctl", ctl(), 32'h0);
    tick();
    chk("t6_rst_hold", ctl(), 32'h0);
    chk("t6_rst_tmo", {31'd0, md_timeout}, 32'd0);
    rst_n = 1;
    tick(); #1;
    chk("t6_after_rst", ctl(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end
endmodule
